// File: rtl/mem_dma_pkg.sv
// Shared types and default widths for the memory DMA engine.
// Operation codes and FSM states used by the top and the address generator.
package mem_dma_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int SUM_W_DEF  = 16;

  typedef enum logic [1:0] {
    OP_COPY = 2'b00,
    OP_FILL = 2'b01,
    OP_SUM  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mem_dma_addr_gen.sv
// Source/destination pointers and remaining byte count.
// Exposes next-cycle pointer values so the top can register its address.
module mem_dma_addr_gen
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic              adv_src_i,
  input  logic              adv_dst_i,
  input  logic              dec_i,
  output logic [ADDR_W-1:0] src_nxt_o,
  output logic [ADDR_W-1:0] dst_nxt_o,
  output logic              zero_o
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      cnt_d = len_i;
    end else begin
      if (adv_src_i) src_d = src_q + ADDR_W'(1);
      if (adv_dst_i) dst_d = dst_q + ADDR_W'(1);
      if (dec_i)     cnt_d = cnt_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

  assign src_nxt_o = src_d;
  assign dst_nxt_o = dst_d;
  assign zero_o    = (cnt_d == '0);

endmodule

// File: rtl/mem_dma_engine.sv
// Block COPY/FILL/SUM initiator for a 4096x8 async-read memory.
// Outputs are registered from next-state values so accesses start at T+1.
module mem_dma_engine
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e state_q, state_d;
  op_e    op_q, op_d, op_in;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic busy_q, busy_d, done_q, done_d;
  logic rd_q, rd_d, wr_q, wr_d;

  logic load, adv_src, adv_dst, dec, zero;
  logic [ADDR_W-1:0] src_nxt, dst_nxt;

  assign op_in = op_e'(op);

  mem_dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .src_i     (src_addr),
    .dst_i     (dst_addr),
    .len_i     (len),
    .adv_src_i (adv_src),
    .adv_dst_i (adv_dst),
    .dec_i     (dec),
    .src_nxt_o (src_nxt),
    .dst_nxt_o (dst_nxt),
    .zero_o    (zero)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fill_d  = fill_q;
    sum_d   = sum_q;
    load    = 1'b0;
    adv_src = 1'b0;
    adv_dst = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          op_d   = op_in;
          fill_d = fill_val;
          if (op_in == OP_SUM) sum_d = '0;
          if (len == '0 || op_in == OP_RSVD) state_d = DONE;
          else if (op_in == OP_FILL)         state_d = WR;
          else                               state_d = RD;
        end
      end
      RD: begin
        adv_src = 1'b1;
        if (op_q == OP_SUM) begin
          dec     = 1'b1;
          sum_d   = sum_q + {{(SUM_W-DATA_W){1'b0}}, mem_dout};
          state_d = zero ? DONE : RD;
        end else begin
          state_d = WR;
        end
        if (abort) state_d = IDLE;
      end
      WR: begin
        adv_dst = 1'b1;
        dec     = 1'b1;
        if (zero)                 state_d = DONE;
        else if (op_q == OP_COPY) state_d = RD;
        else                      state_d = WR;
        if (abort) state_d = IDLE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next-cycle bus values; COPY data is the byte read in the RD cycle now ending
  always_comb begin
    rd_d   = (state_d == RD);
    wr_d   = (state_d == WR);
    busy_d = rd_d || wr_d;
    done_d = (state_d == DONE);
    addr_d = addr_q;
    din_d  = din_q;
    if (rd_d) addr_d = src_nxt;
    if (wr_d) begin
      addr_d = dst_nxt;
      din_d  = (op_d == OP_FILL) ? fill_d : mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_COPY;
      fill_q  <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine with a 4096x8 memory model.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mem_dma_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [11:0] src_addr;
  logic [11:0] dst_addr;
  logic [11:0] len;
  logic [7:0]  fill_val;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_dout;

  logic [7:0]  mem [4096];
  logic        tb_wr;
  logic        tb_clr;
  logic [11:0] tb_a;
  logic [7:0]  tb_d;

  int passed;
  int total;
  int failed;
  int n;

  mem_dma_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_val  (fill_val),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_din;
    end else if (tb_wr) begin
      mem[tb_a] <= tb_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    tb_a  = a;
    tb_d  = d;
    tb_wr = 1'b1;
    tick();
    tb_wr = 1'b0;
  endtask

  task automatic go(input logic [1:0] o, input logic [11:0] s,
                    input logic [11:0] d, input logic [11:0] l,
                    input logic [7:0] f);
    op       = o;
    src_addr = s;
    dst_addr = d;
    len      = l;
    fill_val = f;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Call in cycle T+1; returns n such that done was seen in cycle T+n
  task automatic wait_done(input int max, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    failed   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    fill_val = '0;
    abort    = 1'b0;
    tb_wr    = 1'b0;
    tb_a     = '0;
    tb_d     = '0;
    tb_clr   = 1'b1;
    tick();
    tb_clr   = 1'b0;
    tick();
    reset    = 1'b0;
    tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rdwr", 32'({mem_read, mem_write}), 32'd0);

    poke(12'd0, 8'd5);
    poke(12'd86, 8'd24);

    // COPY 0 -> 100, one byte
    go(2'b00, 12'd0, 12'd100, 12'd1, 8'h00);
    check("cp1_rd", 32'({mem_read, mem_write, busy}), 32'b101);
    check("cp1_rd_addr", 32'(mem_addr), 32'd0);
    tick();
    check("cp1_wr", 32'({mem_read, mem_write}), 32'b01);
    check("cp1_wr_addr", 32'(mem_addr), 32'd100);
    check("cp1_wr_din", 32'(mem_din), 32'd5);
    tick();
    check("cp1_done", 32'({done, busy, mem_write}), 32'b100);
    check("cp1_mem", 32'(mem[100]), 32'd5);
    tick();
    check("cp1_done_pulse", 32'(done), 32'd0);

    // SUM 0..86
    go(2'b10, 12'd0, 12'd0, 12'd87, 8'h00);
    wait_done(200, n);
    check("sum87_lat", 32'(n), 32'd88);
    check("sum87_val", 32'(sum), 32'd29);
    check("sum87_bus", 32'({busy, mem_read}), 32'd0);
    tick();

    for (int i = 0; i < 300; i++) poke(12'(1000 + i), 8'hFF);
    go(2'b10, 12'd1000, 12'd0, 12'd300, 8'h00);
    wait_done(400, n);
    check("sum300_lat", 32'(n), 32'd301);
    check("sum300_val", 32'(sum), 32'h2AD4);
    tick();

    // FILL across the wrap point
    go(2'b01, 12'd0, 12'd4094, 12'd4, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      check("fill_wr", 32'({mem_read, mem_write}), 32'b01);
      check("fill_addr", 32'(mem_addr), 32'((4094 + i) % 4096));
      check("fill_din", 32'(mem_din), 32'hA5);
      tick();
    end
    check("fill_done", 32'(done), 32'd1);
    check("fill_m4095", 32'(mem[4095]), 32'hA5);
    check("fill_m1", 32'(mem[1]), 32'hA5);
    check("fill_m2", 32'(mem[2]), 32'h00);
    check("fill_sum_hold", 32'(sum), 32'h2AD4);
    tick();

    // Overlapping forward COPY replicates the first byte
    poke(12'd10, 8'd7);
    go(2'b00, 12'd10, 12'd11, 12'd3, 8'h00);
    wait_done(50, n);
    check("ovl_lat", 32'(n), 32'd7);
    check("ovl_m11", 32'(mem[11]), 32'd7);
    check("ovl_m12", 32'(mem[12]), 32'd7);
    check("ovl_m13", 32'(mem[13]), 32'd7);
    check("ovl_m14", 32'(mem[14]), 32'd0);
    tick();

    // Abort during the third write of an 8-byte COPY
    go(2'b00, 12'd1000, 12'd200, 12'd8, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    check("ab_wr3", 32'({mem_write, mem_addr}), 32'({1'b1, 12'd202}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle", 32'({busy, done, mem_read, mem_write}), 32'd0);
    check("ab_m202", 32'(mem[202]), 32'hFF);
    check("ab_m203", 32'(mem[203]), 32'h00);
    check("ab_sum_hold", 32'(sum), 32'h2AD4);
    go(2'b01, 12'd0, 12'd300, 12'd1, 8'h3C);
    check("ab_restart", 32'({mem_write, mem_addr}), 32'({1'b1, 12'd300}));
    tick();
    check("ab_restart_done", 32'(done), 32'd1);
    check("ab_restart_mem", 32'(mem[300]), 32'h3C);
    tick();

    // start while busy ignored, then reset mid-SUM
    go(2'b10, 12'd1000, 12'd0, 12'd300, 8'h00);
    tick();
    op       = 2'b01;
    dst_addr = 12'd500;
    len      = 12'd2;
    start    = 1'b1;
    tick();
    tick();
    start    = 1'b0;
    check("busy_start_ign", 32'({mem_read, mem_write, busy}), 32'b101);
    check("busy_start_addr", 32'(mem_addr), 32'd1003);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_ctl", 32'({busy, done, mem_read, mem_write}), 32'd0);
    check("mrst_sum", 32'(sum), 32'd0);
    check("mrst_addr_din", 32'({mem_addr, mem_din}), 32'd0);
    tick();
    check("mrst_stay", 32'({busy, mem_read, mem_write}), 32'd0);
    check("mrst_no_fill", 32'(mem[500]), 32'd0);

    // len=0 and reserved op finish at T+1 with no access
    go(2'b00, 12'd0, 12'd600, 12'd0, 8'h00);
    check("len0_done", 32'({done, busy, mem_read, mem_write}), 32'b1000);
    tick();
    check("len0_after", 32'({done, mem_read, mem_write}), 32'd0);
    go(2'b11, 12'd0, 12'd600, 12'd5, 8'h00);
    check("rsvd_done", 32'({done, busy, mem_read, mem_write}), 32'b1000);
    tick();
    check("rsvd_mem", 32'(mem[600]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
